// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// steps and drives the ALU op select plus every datapath enable.
module unidade_controle_multiciclo #(
    parameter int LARGURA_CONT = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [5:0]              opcode,
    input  logic [5:0]              funct,
    input  logic                    zero,
    input  logic                    memPronto,
    output logic                    pcEscrita,
    output logic                    iouD,
    output logic                    memLeitura,
    output logic                    memEscrita,
    output logic                    irEscrita,
    output logic                    regDst,
    output logic                    memParaReg,
    output logic                    regEscrita,
    output logic                    aluFonteA,
    output logic [1:0]              aluFonteB,
    output logic [1:0]              pcFonte,
    output logic [3:0]              unidadeControle,
    output logic [3:0]              estado,
    output logic                    instrInvalida,
    output logic [LARGURA_CONT-1:0] contadorInstrucoes
);

    typedef enum logic [3:0] {
        BUSCA           = 4'd0,
        DECODIFICA      = 4'd1,
        CALC_END        = 4'd2,
        LE_MEM          = 4'd3,
        ESCREVE_REG_MEM = 4'd4,
        ESCREVE_MEM     = 4'd5,
        EXECUTA_R       = 4'd6,
        ESCREVE_REG_R   = 4'd7,
        DESVIO          = 4'd8,
        SALTO           = 4'd9,
        EXECUTA_I       = 4'd10,
        ESCREVE_REG_I   = 4'd11
    } estado_t;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2,
                           OP_SUB = 4'd3, OP_SLT = 4'd4, OP_NOR = 4'd5;

    estado_t                 r_estado;
    logic                    r_instrInvalida;
    logic [LARGURA_CONT-1:0] r_cont;

    logic       w_functOk;
    logic [3:0] w_opFunct;

    always_comb begin
        w_functOk = 1'b1;
        w_opFunct = OP_AND;
        case (funct)
            6'h24:   w_opFunct = OP_AND;
            6'h25:   w_opFunct = OP_OR;
            6'h20:   w_opFunct = OP_ADD;
            6'h22:   w_opFunct = OP_SUB;
            6'h2A:   w_opFunct = OP_SLT;
            6'h27:   w_opFunct = OP_NOR;
            default: w_functOk = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado        <= BUSCA;
            r_instrInvalida <= 1'b0;
            r_cont          <= '0;
        end else begin
            case (r_estado)
                BUSCA: if (memPronto) begin
                    r_estado        <= DECODIFICA;
                    r_instrInvalida <= 1'b0;
                    r_cont          <= r_cont + LARGURA_CONT'(1);
                end
                DECODIFICA: case (opcode)
                    6'h00:        r_estado <= EXECUTA_R;
                    6'h23, 6'h2B: r_estado <= CALC_END;
                    6'h04:        r_estado <= DESVIO;
                    6'h02:        r_estado <= SALTO;
                    6'h08:        r_estado <= EXECUTA_I;
                    default: begin
                        r_estado        <= BUSCA;
                        r_instrInvalida <= 1'b1;
                    end
                endcase
                EXECUTA_R: if (w_functOk) r_estado <= ESCREVE_REG_R;
                           else begin
                               r_estado        <= BUSCA;
                               r_instrInvalida <= 1'b1;
                           end
                CALC_END:    r_estado <= (opcode == 6'h23) ? LE_MEM : ESCREVE_MEM;
                LE_MEM:      if (memPronto) r_estado <= ESCREVE_REG_MEM;
                ESCREVE_MEM: if (memPronto) r_estado <= BUSCA;
                EXECUTA_I:   r_estado <= ESCREVE_REG_I;
                // single-step write-back states, DESVIO, SALTO and illegal codes
                default:     r_estado <= BUSCA;
            endcase
        end
    end

    logic       w_pcEsc, w_iouD, w_memLe, w_memEsc, w_irEsc, w_regDst;
    logic       w_memParaReg, w_regEsc, w_aluA;
    logic [1:0] w_aluB, w_pcFonte;
    logic [3:0] w_op;

    always_comb begin
        w_pcEsc = 1'b0; w_iouD = 1'b0; w_memLe = 1'b0; w_memEsc = 1'b0;
        w_irEsc = 1'b0; w_regDst = 1'b0; w_memParaReg = 1'b0; w_regEsc = 1'b0;
        w_aluA = 1'b0; w_aluB = 2'd0; w_pcFonte = 2'd0; w_op = OP_AND;
        case (r_estado)
            BUSCA: begin
                w_memLe = 1'b1; w_aluB = 2'd1; w_op = OP_ADD;
                w_irEsc = memPronto; w_pcEsc = memPronto;
            end
            DECODIFICA:      begin w_aluB = 2'd3; w_op = OP_ADD; end
            CALC_END:        begin w_aluA = 1'b1; w_aluB = 2'd2; w_op = OP_ADD; end
            LE_MEM:          begin w_memLe = 1'b1; w_iouD = 1'b1; end
            ESCREVE_REG_MEM: begin w_regEsc = 1'b1; w_memParaReg = 1'b1; end
            ESCREVE_MEM:     begin w_memEsc = 1'b1; w_iouD = 1'b1; end
            EXECUTA_R:       begin w_aluA = 1'b1; w_op = w_functOk ? w_opFunct : OP_AND; end
            ESCREVE_REG_R:   begin w_regEsc = 1'b1; w_regDst = 1'b1; end
            DESVIO: begin
                w_aluA = 1'b1; w_op = OP_SUB; w_pcFonte = 2'd1; w_pcEsc = zero;
            end
            SALTO:           begin w_pcFonte = 2'd2; w_pcEsc = 1'b1; end
            EXECUTA_I:       begin w_aluA = 1'b1; w_aluB = 2'd2; w_op = OP_ADD; end
            ESCREVE_REG_I:   w_regEsc = 1'b1;
            default: ;
        endcase
    end

    // write enables are forced low for as long as reset is held
    assign pcEscrita          = w_pcEsc  & reset;
    assign irEscrita          = w_irEsc  & reset;
    assign memEscrita         = w_memEsc & reset;
    assign regEscrita         = w_regEsc & reset;
    assign iouD               = w_iouD;
    assign memLeitura         = w_memLe;
    assign regDst             = w_regDst;
    assign memParaReg         = w_memParaReg;
    assign aluFonteA          = w_aluA;
    assign aluFonteB          = w_aluB;
    assign pcFonte            = w_pcFonte;
    assign unidadeControle    = w_op;
    assign estado             = r_estado;
    assign instrInvalida      = r_instrInvalida;
    assign contadorInstrucoes = r_cont;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control FSM; expected per-cycle outputs
// are queued as stimulus is driven and checked once the DUT settles.
module tb_unidade_controle_multiciclo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = '0, funct = '0;
    logic        zero = 1'b0, memPronto = 1'b0;

    logic        pcEscrita, iouD, memLeitura, memEscrita, irEscrita, regDst;
    logic        memParaReg, regEscrita, aluFonteA, instrInvalida;
    logic [1:0]  aluFonteB, pcFonte;
    logic [3:0]  unidadeControle, estado;
    logic [31:0] contadorInstrucoes;

    logic        pcEscrita4, iouD4, memLeitura4, memEscrita4, irEscrita4, regDst4;
    logic        memParaReg4, regEscrita4, aluFonteA4, instrInvalida4;
    logic [1:0]  aluFonteB4, pcFonte4;
    logic [3:0]  unidadeControle4, estado4;
    logic [3:0]  contador4;

    unidade_controle_multiciclo dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memPronto(memPronto), .pcEscrita(pcEscrita), .iouD(iouD),
        .memLeitura(memLeitura), .memEscrita(memEscrita), .irEscrita(irEscrita),
        .regDst(regDst), .memParaReg(memParaReg), .regEscrita(regEscrita),
        .aluFonteA(aluFonteA), .aluFonteB(aluFonteB), .pcFonte(pcFonte),
        .unidadeControle(unidadeControle), .estado(estado),
        .instrInvalida(instrInvalida), .contadorInstrucoes(contadorInstrucoes)
    );

    unidade_controle_multiciclo #(.LARGURA_CONT(4)) dut4 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .memPronto(memPronto), .pcEscrita(pcEscrita4), .iouD(iouD4),
        .memLeitura(memLeitura4), .memEscrita(memEscrita4), .irEscrita(irEscrita4),
        .regDst(regDst4), .memParaReg(memParaReg4), .regEscrita(regEscrita4),
        .aluFonteA(aluFonteA4), .aluFonteB(aluFonteB4), .pcFonte(pcFonte4),
        .unidadeControle(unidadeControle4), .estado(estado4),
        .instrInvalida(instrInvalida4), .contadorInstrucoes(contador4)
    );

    always #5 clock = ~clock;

    logic [16:0] w_ctrl;
    assign w_ctrl = {pcEscrita, iouD, memLeitura, memEscrita, irEscrita, regDst,
                     memParaReg, regEscrita, aluFonteA, aluFonteB, pcFonte,
                     unidadeControle};

    typedef struct packed {
        logic [3:0]  est;
        logic [16:0] ctrl;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference output table for one state, built from the state description.
    function automatic logic [16:0] exp_ctrl(logic [3:0] s, logic mp, logic z,
                                             logic [5:0] fn, logic rn);
        logic pcE, io, mRd, mWr, irE, rD, m2r, rE, aA;
        logic [1:0] aB, pF;
        logic [3:0] op;
        {pcE, io, mRd, mWr, irE, rD, m2r, rE, aA} = '0;
        aB = 2'd0; pF = 2'd0; op = 4'd0;
        case (s)
            4'd0:  begin mRd = 1; aB = 2'd1; op = 4'd2; pcE = mp; irE = mp; end
            4'd1:  begin aB = 2'd3; op = 4'd2; end
            4'd2:  begin aA = 1; aB = 2'd2; op = 4'd2; end
            4'd3:  begin mRd = 1; io = 1; end
            4'd4:  begin rE = 1; m2r = 1; end
            4'd5:  begin mWr = 1; io = 1; end
            4'd6: begin
                aA = 1;
                case (fn)
                    6'h25: op = 4'd1;
                    6'h20: op = 4'd2;
                    6'h22: op = 4'd3;
                    6'h2A: op = 4'd4;
                    6'h27: op = 4'd5;
                    default: op = 4'd0;
                endcase
            end
            4'd7:  begin rE = 1; rD = 1; end
            4'd8:  begin aA = 1; op = 4'd3; pF = 2'd1; pcE = z; end
            4'd9:  begin pF = 2'd2; pcE = 1; end
            4'd10: begin aA = 1; aB = 2'd2; op = 4'd2; end
            4'd11: rE = 1;
            default: ;
        endcase
        if (!rn) begin pcE = 0; mWr = 0; irE = 0; rE = 0; end
        return {pcE, io, mRd, mWr, irE, rD, m2r, rE, aA, aB, pF, op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, compare, advance a cycle.
    task automatic step(input string tag, input logic [3:0] est, input logic mp,
                        input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e, g;
        opcode = op; funct = fn; memPronto = mp; zero = z;
        e.est  = est;
        e.ctrl = exp_ctrl(est, mp, z, fn, reset);
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check({tag, ".estado"}, 64'(estado), 64'(g.est));
        check({tag, ".ctrl"}, 64'(w_ctrl), 64'(g.ctrl));
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [5:0] fns [5] = '{6'h24, 6'h25, 6'h22, 6'h2A, 6'h27};

    initial begin
        memPronto = 1'b1;
        @(negedge clock);
        #1;
        check("rst.estado", 64'(estado), 64'd0);
        check("rst.ctrl", 64'(w_ctrl), 64'(exp_ctrl(4'd0, 1'b1, 1'b0, 6'h0, 1'b0)));
        check("rst.cnt", 64'(contadorInstrucoes), 64'd0);
        check("rst.inv", 64'(instrInvalida), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        step("add.f", 4'd0, 1, 6'h00, 6'h20, 0);
        check("add.cnt", 64'(contadorInstrucoes), 64'd1);
        step("add.d", 4'd1, 1, 6'h00, 6'h20, 0);
        step("add.x", 4'd6, 1, 6'h00, 6'h20, 0);
        step("add.w", 4'd7, 1, 6'h00, 6'h20, 0);

        step("lw.f", 4'd0, 1, 6'h23, 6'h00, 0);
        step("lw.d", 4'd1, 1, 6'h23, 6'h00, 0);
        step("lw.a", 4'd2, 1, 6'h23, 6'h00, 0);
        for (int i = 0; i < 3; i++) step("lw.stall", 4'd3, 0, 6'h23, 6'h00, 0);
        step("lw.m", 4'd3, 1, 6'h23, 6'h00, 0);
        step("lw.w", 4'd4, 1, 6'h23, 6'h00, 0);

        for (int i = 0; i < 2; i++) begin
            step("beq.f", 4'd0, 1, 6'h04, 6'h00, 0);
            step("beq.d", 4'd1, 1, 6'h04, 6'h00, 0);
            step(i == 0 ? "beq.z1" : "beq.z0", 4'd8, 1, 6'h04, 6'h00, i == 0);
        end

        for (int i = 0; i < 5; i++) begin
            step("rfn.f", 4'd0, 1, 6'h00, fns[i], 0);
            step("rfn.d", 4'd1, 1, 6'h00, fns[i], 0);
            step("rfn.x", 4'd6, 1, 6'h00, fns[i], 0);
            step("rfn.w", 4'd7, 1, 6'h00, fns[i], 0);
        end

        step("addi.f", 4'd0, 1, 6'h08, 6'h00, 0);
        step("addi.d", 4'd1, 1, 6'h08, 6'h00, 0);
        step("addi.x", 4'd10, 1, 6'h08, 6'h00, 0);
        step("addi.w", 4'd11, 1, 6'h08, 6'h00, 0);

        step("badfn.f", 4'd0, 1, 6'h00, 6'h3F, 0);
        step("badfn.d", 4'd1, 1, 6'h00, 6'h3F, 0);
        step("badfn.x", 4'd6, 1, 6'h00, 6'h3F, 0);
        check("badfn.inv", 64'(instrInvalida), 64'd1);
        step("badfn.stall", 4'd0, 0, 6'h00, 6'h20, 0);
        check("badfn.inv_hold", 64'(instrInvalida), 64'd1);
        step("badfn.refetch", 4'd0, 1, 6'h00, 6'h20, 0);
        check("badfn.inv_clr", 64'(instrInvalida), 64'd0);
        step("badfn.d2", 4'd1, 1, 6'h3F, 6'h20, 0);
        check("badop.inv", 64'(instrInvalida), 64'd1);
        step("badop.f", 4'd0, 1, 6'h2B, 6'h00, 0);
        check("badop.inv_clr", 64'(instrInvalida), 64'd0);

        step("sw.d", 4'd1, 1, 6'h2B, 6'h00, 0);
        step("sw.a", 4'd2, 1, 6'h2B, 6'h00, 0);
        step("sw.stall", 4'd5, 0, 6'h2B, 6'h00, 0);
        step("sw.stall", 4'd5, 0, 6'h2B, 6'h00, 0);
        #2;
        reset = 1'b0;
        #1;
        check("swrst.estado", 64'(estado), 64'd0);
        check("swrst.memEscrita", 64'(memEscrita), 64'd0);
        check("swrst.cnt", 64'(contadorInstrucoes), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        step("sw2.f", 4'd0, 1, 6'h2B, 6'h00, 0);
        step("sw2.d", 4'd1, 1, 6'h2B, 6'h00, 0);
        step("sw2.a", 4'd2, 1, 6'h2B, 6'h00, 0);
        step("sw2.m", 4'd5, 1, 6'h2B, 6'h00, 0);

        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check("j.cnt4_15", 64'(contador4), 64'd15);
            step("j.f", 4'd0, 1, 6'h02, 6'h00, 0);
            step("j.d", 4'd1, 1, 6'h02, 6'h00, 0);
            step("j.s", 4'd9, 1, 6'h02, 6'h00, 0);
        end
        check("j.cnt4_wrap", 64'(contador4), 64'd0);
        check("j.cnt32", 64'(contadorInstrucoes), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
